// File: rtl/tile_scroll_mapper_if.sv
// Bus between the VGA timing/compositing logic and tile_scroll_mapper.
// Carries the pixel coordinates, the scroll/animation controls, the external ROM and
// palette connections, and the registered colour/opacity outputs.
//   slave  : the tile renderer (consumes coordinates, drives ROM address and colour)
//   master : the surrounding video system (drives coordinates, ROM data and palette)
interface tile_scroll_mapper_if #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned ADDR_W = 16
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              frame_tick;
  logic              scroll_en;
  logic [3:0]        scroll_step;
  logic              anim_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_idx;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic              opaque;

  modport slave (
    input  DrawX, DrawY, blank, frame_tick, scroll_en, scroll_step, anim_en,
    input  rom_q, pal_red, pal_green, pal_blue,
    output rom_addr, pal_idx, red, green, blue, opaque
  );

  modport master (
    output DrawX, DrawY, blank, frame_tick, scroll_en, scroll_step, anim_en,
    output rom_q, pal_red, pal_green, pal_blue,
    input  rom_addr, pal_idx, red, green, blue, opaque
  );
endinterface

// File: rtl/tile_scroll_mapper.sv
// Background tile renderer: repeats a TILE_W x TILE_H indexed image over the screen with
// power-of-two scaling, horizontal scrolling and frame-based animation.
// Ports:
//   vga_clk  : pixel clock, all state on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of tile_scroll_mapper_if (coordinates, controls, ROM address/data,
//              palette index/colour, registered RGB + opacity, 2-cycle pixel latency)
module tile_scroll_mapper #(
  parameter int unsigned TILE_W          = 96,
  parameter int unsigned TILE_H          = 96,
  parameter int unsigned SCALE_LOG2      = 1,
  parameter int unsigned NUM_FRAMES      = 4,
  parameter int unsigned ANIM_PERIOD     = 8,
  parameter int unsigned IDX_W           = 2,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input logic                vga_clk,
  input logic                reset_n,
  tile_scroll_mapper_if.slave bus
);

  localparam int unsigned SP         = TILE_W << SCALE_LOG2;
  localparam int unsigned SCROLL_W   = (SP > 1) ? $clog2(SP) : 1;
  localparam int unsigned FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned ANIM_W     = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int unsigned FRAME_SIZE = TILE_W * TILE_H;

  logic [SCROLL_W-1:0] scroll_x_q, scroll_x_d;
  logic [ANIM_W-1:0]   anim_cnt_q, anim_cnt_d;
  logic [FRAME_W-1:0]  frame_idx_q, frame_idx_d;
  logic                blank_d_q;
  logic [3:0]          red_q, green_q, blue_q;
  logic                opaque_q;

  logic [10:0]         sx;
  logic [31:0]         tx, ty;
  logic [ADDR_W-1:0]   rom_addr;
  logic                anim_last, frame_last;

  // Coordinate path: scrolled X and plain Y reduced to source-pixel tile coordinates.
  always_comb begin
    sx       = 11'(bus.DrawX) + 11'(scroll_x_q);
    tx       = 32'(sx >> SCALE_LOG2) % TILE_W;
    ty       = 32'(bus.DrawY >> SCALE_LOG2) % TILE_H;
    rom_addr = ADDR_W'(32'(frame_idx_q) * FRAME_SIZE + ty * TILE_W + tx);
  end

  assign bus.rom_addr = rom_addr;
  assign bus.pal_idx  = bus.rom_q;

  // Scroll and animation state advance only on frame_tick, independently of each other.
  always_comb begin
    scroll_x_d  = scroll_x_q;
    anim_cnt_d  = anim_cnt_q;
    frame_idx_d = frame_idx_q;
    anim_last   = (32'(anim_cnt_q) == ANIM_PERIOD - 1);
    frame_last  = (32'(frame_idx_q) >= NUM_FRAMES - 1);

    if (bus.frame_tick && bus.scroll_en) begin
      // Full modulo so that a step larger than the period still wraps correctly.
      scroll_x_d = SCROLL_W'((32'(scroll_x_q) + 32'(bus.scroll_step)) % SP);
    end

    if (bus.frame_tick && bus.anim_en) begin
      if (anim_last) begin
        anim_cnt_d  = '0;
        frame_idx_d = frame_last ? '0 : frame_idx_q + FRAME_W'(1);
      end else begin
        anim_cnt_d  = anim_cnt_q + ANIM_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      scroll_x_q  <= '0;
      anim_cnt_q  <= '0;
      frame_idx_q <= '0;
    end else begin
      scroll_x_q  <= scroll_x_d;
      anim_cnt_q  <= anim_cnt_d;
      frame_idx_q <= frame_idx_d;
    end
  end

  // Output stage: blank is delayed one cycle to line up with rom_q, then colour is registered.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      opaque_q  <= 1'b0;
    end else begin
      blank_d_q <= bus.blank;
      if (blank_d_q) begin
        red_q    <= bus.pal_red;
        green_q  <= bus.pal_green;
        blue_q   <= bus.pal_blue;
        opaque_q <= (bus.rom_q != IDX_W'(TRANSPARENT_IDX));
      end else begin
        red_q    <= '0;
        green_q  <= '0;
        blue_q   <= '0;
        opaque_q <= 1'b0;
      end
    end
  end

  assign bus.red    = red_q;
  assign bus.green  = green_q;
  assign bus.blue   = blue_q;
  assign bus.opaque = opaque_q;

endmodule

// File: tb/tb_tile_scroll_mapper.sv
module tb_tile_scroll_mapper;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tile_scroll_mapper_if #(.IDX_W(2), .ADDR_W(16)) bus ();

  tile_scroll_mapper #(
    .TILE_W(96), .TILE_H(96), .SCALE_LOG2(1), .NUM_FRAMES(4), .ANIM_PERIOD(8),
    .IDX_W(2), .ADDR_W(16), .TRANSPARENT_IDX(0)
  ) dut (
    .vga_clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  int m_scroll = 0;
  int m_frame  = 0;
  int m_cnt    = 0;

  function automatic logic [1:0] rom_fn(input logic [15:0] a);
    logic [15:0] t;
    t = a ^ (a >> 3);
    return t[1:0];
  endfunction

  function automatic logic [11:0] pal_fn(input logic [1:0] i);
    case (i)
      2'd0:    return 12'h123;
      2'd1:    return 12'h456;
      2'd2:    return 12'hF80;
      2'd3:    return 12'hABC;
      default: return 12'h000;
    endcase
  endfunction

  function automatic int maddr(input int x, input int y);
    return m_frame * 9216 + ((y >> 1) % 96) * 96 + (((x + m_scroll) >> 1) % 96);
  endfunction

  // External ROM (1-cycle latency) and combinational palette
  always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);
  assign {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_fn(bus.pal_idx);

  typedef struct {int x; int y; bit b;} pix_t;
  typedef struct {logic [11:0] rgb; logic opq; int due;} exp_t;
  pix_t pix_q[$];
  exp_t exp_q[$];

  // Drives pix_q one pixel per cycle, checks rom_addr in-cycle and the scoreboard at t+2.
  task automatic stream();
    int n;
    n = pix_q.size();
    for (int k = 0; k < n + 2; k++) begin
      int x, y, a;
      bit b;
      exp_t e;
      logic [1:0] idx;
      x = 0; y = 0; b = 1'b0;
      if (k < n) begin
        x = pix_q[k].x; y = pix_q[k].y; b = pix_q[k].b;
      end
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      bus.blank = b;
      a = maddr(x, y);
      idx = rom_fn(16'(a));
      if (k < n) begin
        e.rgb = b ? pal_fn(idx) : 12'h000;
        e.opq = b && (idx != 2'd0);
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
      @(negedge clk);
      vecs++;
      if (bus.rom_addr !== 16'(a)) begin
        errs++;
        $display("FAIL rom_addr x=%0d y=%0d: got %0d expected %0d", x, y, bus.rom_addr, a);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        vecs++;
        if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.opaque !== e.opq) begin
          errs++;
          $display("FAIL pixel_out cyc=%0d: got rgb=%h opaque=%b expected rgb=%h opaque=%b",
                   cyc, {bus.red, bus.green, bus.blue}, bus.opaque, e.rgb, e.opq);
        end
      end
      @(posedge clk);
      #1;
    end
    pix_q.delete();
  endtask

  task automatic tick(input bit se, input bit ae, input int step);
    bus.frame_tick  = 1'b1;
    bus.scroll_en   = se;
    bus.anim_en     = ae;
    bus.scroll_step = 4'(step);
    bus.blank       = 1'b0;
    @(posedge clk);
    if (se) m_scroll = (m_scroll + step) % 192;
    if (ae) begin
      if (m_cnt == 7) begin
        m_cnt = 0;
        m_frame = (m_frame + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    #1;
    bus.frame_tick = 1'b0;
    bus.scroll_en  = 1'b0;
    bus.anim_en    = 1'b0;
  endtask

  task automatic push_pix(input int x, input int y, input bit b);
    pix_t p;
    p.x = x; p.y = y; p.b = b;
    pix_q.push_back(p);
  endtask

  task automatic test_reset();
    bus.DrawX = 10'd5; bus.DrawY = 10'd3; bus.blank = 1'b1;
    bus.frame_tick = 1'b0; bus.scroll_en = 1'b0; bus.anim_en = 1'b0; bus.scroll_step = 4'd0;
    reset_n = 1'b0;
    #22;
    vecs++;
    if ({bus.red, bus.green, bus.blue} !== 12'h000 || bus.opaque !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got rgb=%h opaque=%b expected 000/0",
               {bus.red, bus.green, bus.blue}, bus.opaque);
    end
    vecs++;
    if (bus.rom_addr !== 16'd98) begin
      errs++;
      $display("FAIL reset_rom_addr: got %0d expected 98", bus.rom_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    push_pix(5, 3, 1'b1);
    push_pix(6, 3, 1'b1);
    push_pix(40, 77, 1'b1);
    stream();
  endtask

  task automatic test_blank_transparent();
    push_pix(5, 3, 1'b0);
    push_pix(0, 0, 1'b1);
    push_pix(2, 0, 1'b1);
    push_pix(0, 0, 1'b0);
    stream();
  endtask

  task automatic test_scroll_wrap();
    repeat (38) tick(1'b1, 1'b0, 5);
    push_pix(0, 0, 1'b1);
    push_pix(10, 4, 1'b1);
    stream();
    tick(1'b1, 1'b0, 5);
    push_pix(0, 0, 1'b1);
    push_pix(191, 20, 1'b1);
    stream();
  endtask

  task automatic test_animation();
    repeat (8) tick(1'b0, 1'b1, 0);
    push_pix(0, 0, 1'b1);
    push_pix(30, 60, 1'b1);
    stream();
    repeat (24) tick(1'b0, 1'b1, 0);
    push_pix(0, 0, 1'b1);
    stream();
    repeat (5) tick(1'b1, 1'b0, 0);
    repeat (3) tick(1'b0, 1'b0, 3);
    // Enables held high without frame_tick must not advance anything.
    bus.scroll_en = 1'b1; bus.anim_en = 1'b1; bus.scroll_step = 4'd9;
    repeat (4) @(posedge clk);
    #1;
    bus.scroll_en = 1'b0; bus.anim_en = 1'b0;
    push_pix(12, 12, 1'b1);
    push_pix(300, 200, 1'b1);
    stream();
  endtask

  task automatic test_simultaneous();
    while (m_cnt != 7) tick(1'b0, 1'b1, 0);
    push_pix(4, 8, 1'b1);
    stream();
    tick(1'b1, 1'b1, 7);
    push_pix(4, 8, 1'b1);
    push_pix(0, 0, 1'b1);
    stream();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      push_pix($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0));
    end
    stream();
    tick(1'b1, 1'b1, 15);
    for (int i = 0; i < 20; i++) begin
      push_pix($urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1);
    end
    stream();
  endtask

  task automatic test_reset_midline();
    int a;
    logic [11:0] exp_rgb;
    tick(1'b1, 1'b0, 9);
    repeat (8) tick(1'b0, 1'b1, 0);
    bus.DrawX = 10'd5; bus.DrawY = 10'd3; bus.blank = 1'b1;
    a = maddr(5, 3);
    exp_rgb = pal_fn(rom_fn(16'(a)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({bus.red, bus.green, bus.blue} !== exp_rgb) begin
      errs++;
      $display("FAIL pre_reset_rgb: got %h expected %h", {bus.red, bus.green, bus.blue}, exp_rgb);
    end
    #2;
    reset_n = 1'b0;
    m_scroll = 0; m_frame = 0; m_cnt = 0;
    #1;
    vecs++;
    if ({bus.red, bus.green, bus.blue} !== 12'h000 || bus.opaque !== 1'b0) begin
      errs++;
      $display("FAIL midline_reset_out: got rgb=%h opaque=%b expected 000/0",
               {bus.red, bus.green, bus.blue}, bus.opaque);
    end
    vecs++;
    if (bus.rom_addr !== 16'(maddr(5, 3))) begin
      errs++;
      $display("FAIL midline_reset_addr: got %0d expected %0d", bus.rom_addr, maddr(5, 3));
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    push_pix(5, 3, 1'b1);
    push_pix(7, 9, 1'b1);
    push_pix(100, 50, 1'b1);
    push_pix(3, 3, 1'b0);
    stream();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank_transparent();
    test_scroll_wrap();
    test_animation();
    test_simultaneous();
    test_back_to_back();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
